// File: rtl/commit_monitor.sv
// Simulation-side commit monitor: shadow GPR file, cycle/instret counters,
// a ring buffer of recent commits and the ebreak/timeout halt state machine.
module commit_monitor #(
    parameter int XLEN         = 64,
    parameter int NR_GPR       = 32,
    parameter int COMMIT_W     = 1,
    parameter int TRACE_DEPTH  = 16,
    parameter int DRAIN_CYCLES = 2,
    parameter int TIMEOUT      = 4096,
    localparam int RW          = $clog2(NR_GPR),
    localparam int TW          = $clog2(TRACE_DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [COMMIT_W-1:0]      commit_valid,
    input  logic [COMMIT_W*XLEN-1:0] commit_pc,
    input  logic [COMMIT_W*32-1:0]   commit_inst,
    input  logic [COMMIT_W-1:0]      commit_wen,
    input  logic [COMMIT_W*RW-1:0]   commit_rd,
    input  logic [COMMIT_W*XLEN-1:0] commit_wdata,
    input  logic [COMMIT_W-1:0]      commit_ebreak,
    input  logic [RW-1:0]            gpr_raddr,
    output logic [XLEN-1:0]          gpr_rdata,
    input  logic [TW-1:0]            trace_ridx,
    output logic [XLEN-1:0]          trace_rpc,
    output logic [31:0]              trace_rinst,
    output logic [TW:0]              trace_count,
    output logic [1:0]               state,
    output logic                     halt,
    output logic [1:0]               halt_code,
    output logic [XLEN-1:0]          halt_pc,
    output logic [63:0]              cycle_cnt,
    output logic [63:0]              instret_cnt
);

    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam int DW  = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t cur_state;
    state_t next_state;

    logic [XLEN-1:0] gpr     [NR_GPR];
    logic [XLEN-1:0] tr_pc   [TRACE_DEPTH];
    logic [31:0]     tr_inst [TRACE_DEPTH];
    logic [TW-1:0]   wptr;
    logic [WDW-1:0]  wd_cnt;
    logic [DW-1:0]   drain_cnt;
    logic [XLEN-1:0] last_pc;

    logic            can_accept;
    logic [COMMIT_W-1:0] acc;
    logic            blocked;
    logic            any_acc;
    logic            ebreak_hit;
    logic [XLEN-1:0] ebreak_pc;
    logic [XLEN-1:0] youngest_pc;
    logic [1:0]      n_acc;
    logic [TW-1:0]   slot;
    logic [TW-1:0]   wr_idx [COMMIT_W];
    logic            wd_expire;
    logic            drain_done;
    logic [TW+1:0]   count_sum;
    logic [TW:0]     count_next;
    logic [TW-1:0]   rd_slot;

    assign can_accept = (cur_state == IDLE) || (cur_state == RUN);

    // Channels younger than an accepted ebreak are dropped; each accepted
    // channel claims the next ring-buffer slot in age order.
    always_comb begin
        acc         = '0;
        blocked     = 1'b0;
        ebreak_hit  = 1'b0;
        ebreak_pc   = '0;
        youngest_pc = last_pc;
        n_acc       = '0;
        slot        = wptr;
        for (int i = 0; i < COMMIT_W; i++) begin
            wr_idx[i] = slot;
            if (can_accept && commit_valid[i] && !blocked) begin
                acc[i]      = 1'b1;
                n_acc       = n_acc + 2'd1;
                slot        = slot + TW'(1);
                youngest_pc = commit_pc[i*XLEN +: XLEN];
                if (commit_ebreak[i]) begin
                    blocked    = 1'b1;
                    ebreak_hit = 1'b1;
                    ebreak_pc  = commit_pc[i*XLEN +: XLEN];
                end
            end
        end
    end

    assign any_acc    = |acc;
    assign wd_expire  = can_accept && !any_acc && (wd_cnt == WDW'(TIMEOUT - 1));
    assign drain_done = (cur_state == DRAIN) && (drain_cnt == DW'(DRAIN_CYCLES - 1));
    assign count_sum  = {1'b0, trace_count} + (TW+2)'(n_acc);
    assign count_next = (count_sum > (TW+2)'(TRACE_DEPTH)) ? (TW+1)'(TRACE_DEPTH)
                                                           : count_sum[TW:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= next_state;
        end
    end

    // An accepted ebreak always wins over watchdog expiry, since expiry
    // requires a cycle without any accepted commit.
    always_comb begin
        next_state = cur_state;
        case (cur_state)
            IDLE, RUN: begin
                if (ebreak_hit) begin
                    next_state = DRAIN;
                end else if (wd_expire) begin
                    next_state = HALT;
                end else if (any_acc) begin
                    next_state = RUN;
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    next_state = HALT;
                end
            end
            default: next_state = HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int g = 0; g < NR_GPR; g++) begin
                gpr[g] <= '0;
            end
            for (int t = 0; t < TRACE_DEPTH; t++) begin
                tr_pc[t]   <= '0;
                tr_inst[t] <= '0;
            end
            wptr        <= '0;
            trace_count <= '0;
            wd_cnt      <= '0;
            drain_cnt   <= '0;
            last_pc     <= '0;
            halt_code   <= '0;
            halt_pc     <= '0;
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if ((cur_state == RUN) || (cur_state == DRAIN)) begin
                cycle_cnt <= cycle_cnt + 64'd1;
            end
            instret_cnt <= instret_cnt + 64'(n_acc);
            wptr        <= slot;
            trace_count <= count_next;
            // Later (younger) channel is written last so it wins on equal rd.
            for (int i = 0; i < COMMIT_W; i++) begin
                if (acc[i]) begin
                    tr_pc[wr_idx[i]]   <= commit_pc[i*XLEN +: XLEN];
                    tr_inst[wr_idx[i]] <= commit_inst[i*32 +: 32];
                    if (commit_wen[i] && (commit_rd[i*RW +: RW] != '0)) begin
                        gpr[commit_rd[i*RW +: RW]] <= commit_wdata[i*XLEN +: XLEN];
                    end
                end
            end
            if (any_acc) begin
                last_pc <= youngest_pc;
            end
            if (any_acc || !can_accept) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + WDW'(1);
            end
            if (cur_state == DRAIN) begin
                drain_cnt <= drain_cnt + DW'(1);
            end else begin
                drain_cnt <= '0;
            end
            if (ebreak_hit) begin
                halt_pc <= ebreak_pc;
            end else if (wd_expire) begin
                halt_pc   <= last_pc;
                halt_code <= 2'd3;
            end
            if (drain_done) begin
                halt_code <= (gpr[10] == '0) ? 2'd1 : 2'd2;
            end
        end
    end

    assign rd_slot     = wptr - TW'(1) - trace_ridx;
    assign trace_rpc   = ({1'b0, trace_ridx} < trace_count) ? tr_pc[rd_slot] : '0;
    assign trace_rinst = ({1'b0, trace_ridx} < trace_count) ? tr_inst[rd_slot] : '0;
    assign gpr_rdata   = (gpr_raddr == '0) ? '0 : gpr[gpr_raddr];
    assign state       = cur_state;
    assign halt        = (cur_state == HALT);

endmodule

// File: tb/tb_commit_monitor.sv
// Directed self-checking bench for commit_monitor with two commit channels
// and a short watchdog so timeout behaviour is reachable quickly.
module tb_commit_monitor;

    logic         clk;
    logic         rst_n;
    logic [1:0]   commit_valid;
    logic [127:0] commit_pc;
    logic [63:0]  commit_inst;
    logic [1:0]   commit_wen;
    logic [9:0]   commit_rd;
    logic [127:0] commit_wdata;
    logic [1:0]   commit_ebreak;
    logic [4:0]   gpr_raddr;
    logic [63:0]  gpr_rdata;
    logic [3:0]   trace_ridx;
    logic [63:0]  trace_rpc;
    logic [31:0]  trace_rinst;
    logic [4:0]   trace_count;
    logic [1:0]   state;
    logic         halt;
    logic [1:0]   halt_code;
    logic [63:0]  halt_pc;
    logic [63:0]  cycle_cnt;
    logic [63:0]  instret_cnt;

    int checks;
    int failures;

    commit_monitor #(
        .XLEN(64), .NR_GPR(32), .COMMIT_W(2),
        .TRACE_DEPTH(16), .DRAIN_CYCLES(2), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_inst(commit_inst),
        .commit_wen(commit_wen), .commit_rd(commit_rd), .commit_wdata(commit_wdata),
        .commit_ebreak(commit_ebreak),
        .gpr_raddr(gpr_raddr), .gpr_rdata(gpr_rdata),
        .trace_ridx(trace_ridx), .trace_rpc(trace_rpc), .trace_rinst(trace_rinst),
        .trace_count(trace_count),
        .state(state), .halt(halt), .halt_code(halt_code), .halt_pc(halt_pc),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] v, input logic [1:0] eb, input logic [1:0] wen,
                                 input logic [63:0] pc0, input logic [31:0] in0,
                                 input logic [4:0] rd0, input logic [63:0] wd0,
                                 input logic [63:0] pc1, input logic [31:0] in1,
                                 input logic [4:0] rd1, input logic [63:0] wd1);
        commit_valid  = v;
        commit_ebreak = eb;
        commit_wen    = wen;
        commit_pc     = {pc1, pc0};
        commit_inst   = {in1, in0};
        commit_rd     = {rd1, rd0};
        commit_wdata  = {wd1, wd0};
        @(posedge clk);
        #1;
        commit_valid  = '0;
        commit_ebreak = '0;
        commit_wen    = '0;
    endtask

    task automatic commitOne(input logic [63:0] pc, input logic [31:0] inst, input logic wen,
                             input logic [4:0] rd, input logic [63:0] wd, input logic eb);
        applyStimulus(2'b01, {1'b0, eb}, {1'b0, wen}, pc, inst, rd, wd, 64'd0, 32'd0, 5'd0, 64'd0);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic readGpr(input string tag, input logic [4:0] idx, input logic [63:0] expected);
        gpr_raddr = idx;
        #1;
        checkOutput(tag, gpr_rdata, expected);
    endtask

    task automatic readTrace(input string tag, input logic [3:0] idx,
                             input logic [63:0] exp_pc, input logic [31:0] exp_inst);
        trace_ridx = idx;
        #1;
        checkOutput({tag, "_pc"}, trace_rpc, exp_pc);
        checkOutput({tag, "_inst"}, {32'd0, trace_rinst}, {32'd0, exp_inst});
    endtask

    // Hard stop in case the sequence stalls for any reason.
    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        commit_valid  = '0;
        commit_pc     = '0;
        commit_inst   = '0;
        commit_wen    = '0;
        commit_rd     = '0;
        commit_wdata  = '0;
        commit_ebreak = '0;
        gpr_raddr     = '0;
        trace_ridx    = '0;

        $display("[TB] reset state and basic GPR writes");
        doReset();
        checkOutput("rst_state", {62'd0, state}, 64'd0);
        checkOutput("rst_halt", {63'd0, halt}, 64'd0);
        checkOutput("rst_instret", instret_cnt, 64'd0);
        checkOutput("rst_cycle", cycle_cnt, 64'd0);
        checkOutput("rst_tcount", {59'd0, trace_count}, 64'd0);
        checkOutput("rst_hcode", {62'd0, halt_code}, 64'd0);
        readGpr("rst_x5", 5'd5, 64'd0);
        commitOne(64'h8000_0000, 32'h0000_0293, 1'b1, 5'd5, 64'h1234, 1'b0);
        commitOne(64'h8000_0004, 32'h0ff0_0013, 1'b1, 5'd0, 64'hFF, 1'b0);
        readGpr("gpr_x5", 5'd5, 64'h1234);
        readGpr("gpr_x0", 5'd0, 64'd0);
        checkOutput("t1_instret", instret_cnt, 64'd2);
        checkOutput("t1_state", {62'd0, state}, 64'd1);
        checkOutput("t1_cycle", cycle_cnt, 64'd1);
        checkOutput("t1_tcount", {59'd0, trace_count}, 64'd2);
        readTrace("t1_idx0", 4'd0, 64'h8000_0004, 32'h0ff0_0013);
        readTrace("t1_idx2_empty", 4'd2, 64'd0, 32'd0);

        $display("[TB] trace ring wrap");
        doReset();
        for (int i = 0; i < 20; i++) begin
            commitOne(64'h8000_0000 + 64'(4 * i), 32'h100 + 32'(i), 1'b0, 5'd0, 64'd0, 1'b0);
        end
        checkOutput("t2_tcount", {59'd0, trace_count}, 64'd16);
        readTrace("t2_idx0", 4'd0, 64'h8000_004C, 32'h113);
        readTrace("t2_idx15", 4'd15, 64'h8000_0010, 32'h104);
        checkOutput("t2_instret", instret_cnt, 64'd20);
        checkOutput("t2_cycle", cycle_cnt, 64'd19);

        $display("[TB] ebreak drain with good trap");
        doReset();
        commitOne(64'h8000_00FC, 32'h0000_0513, 1'b1, 5'd10, 64'd0, 1'b0);
        commitOne(64'h8000_0100, 32'h0010_0073, 1'b0, 5'd0, 64'd0, 1'b1);
        checkOutput("t3_state_drain", {62'd0, state}, 64'd2);
        checkOutput("t3_instret_a", instret_cnt, 64'd2);
        commitOne(64'h8000_0104, 32'h0050_0513, 1'b1, 5'd10, 64'd5, 1'b0);
        checkOutput("t3_state_drain2", {62'd0, state}, 64'd2);
        checkOutput("t3_halt_early", {63'd0, halt}, 64'd0);
        checkOutput("t3_instret_b", instret_cnt, 64'd2);
        readGpr("t3_a0_kept", 5'd10, 64'd0);
        commitOne(64'h8000_0108, 32'h0050_0513, 1'b1, 5'd10, 64'd5, 1'b0);
        checkOutput("t3_halt", {63'd0, halt}, 64'd1);
        checkOutput("t3_state_halt", {62'd0, state}, 64'd3);
        checkOutput("t3_hcode", {62'd0, halt_code}, 64'd1);
        checkOutput("t3_hpc", halt_pc, 64'h8000_0100);
        checkOutput("t3_instret_c", instret_cnt, 64'd2);
        checkOutput("t3_cycle", cycle_cnt, 64'd3);
        commitOne(64'h8000_010C, 32'h0000_0013, 1'b0, 5'd0, 64'd0, 1'b0);
        idleCycles(2);
        checkOutput("t3_cycle_frozen", cycle_cnt, 64'd3);
        checkOutput("t3_tcount_frozen", {59'd0, trace_count}, 64'd2);
        checkOutput("t3_state_absorb", {62'd0, state}, 64'd3);

        $display("[TB] dual channel, same rd and ebreak on ch0");
        doReset();
        applyStimulus(2'b11, 2'b00, 2'b11,
                      64'h8000_0000, 32'h0070_0513, 5'd10, 64'd7,
                      64'h8000_0004, 32'h0090_0513, 5'd10, 64'd9);
        readGpr("t4_a0_ch1_wins", 5'd10, 64'd9);
        checkOutput("t4_instret_a", instret_cnt, 64'd2);
        readTrace("t4_idx0", 4'd0, 64'h8000_0004, 32'h0090_0513);
        readTrace("t4_idx1", 4'd1, 64'h8000_0000, 32'h0070_0513);
        applyStimulus(2'b11, 2'b01, 2'b10,
                      64'h8000_0008, 32'h0010_0073, 5'd0, 64'd0,
                      64'h8000_000C, 32'h0000_0513, 5'd10, 64'd0);
        checkOutput("t4_instret_b", instret_cnt, 64'd3);
        checkOutput("t4_state_drain", {62'd0, state}, 64'd2);
        checkOutput("t4_tcount", {59'd0, trace_count}, 64'd3);
        readTrace("t4_newest", 4'd0, 64'h8000_0008, 32'h0010_0073);
        readGpr("t4_a0_unchanged", 5'd10, 64'd9);
        idleCycles(2);
        checkOutput("t4_halt", {63'd0, halt}, 64'd1);
        checkOutput("t4_hcode", {62'd0, halt_code}, 64'd2);
        checkOutput("t4_hpc", halt_pc, 64'h8000_0008);

        $display("[TB] watchdog after one commit");
        doReset();
        commitOne(64'h8000_0200, 32'h0000_0013, 1'b0, 5'd0, 64'd0, 1'b0);
        idleCycles(7);
        checkOutput("t5_halt_early", {63'd0, halt}, 64'd0);
        checkOutput("t5_state_run", {62'd0, state}, 64'd1);
        idleCycles(1);
        checkOutput("t5_halt", {63'd0, halt}, 64'd1);
        checkOutput("t5_hcode", {62'd0, halt_code}, 64'd3);
        checkOutput("t5_hpc", halt_pc, 64'h8000_0200);
        checkOutput("t5_cycle", cycle_cnt, 64'd8);
        checkOutput("t5_instret", instret_cnt, 64'd1);

        $display("[TB] watchdog with no commit at all");
        doReset();
        idleCycles(7);
        checkOutput("t6_halt_early", {63'd0, halt}, 64'd0);
        idleCycles(1);
        checkOutput("t6_hcode", {62'd0, halt_code}, 64'd3);
        checkOutput("t6_hpc", halt_pc, 64'd0);
        checkOutput("t6_cycle", cycle_cnt, 64'd0);

        $display("[TB] reset during drain");
        doReset();
        commitOne(64'h8000_0300, 32'h0ab0_0293, 1'b1, 5'd5, 64'hAB, 1'b0);
        commitOne(64'h8000_0304, 32'h0010_0073, 1'b0, 5'd0, 64'd0, 1'b1);
        checkOutput("t7_state_drain", {62'd0, state}, 64'd2);
        doReset();
        checkOutput("t7_state", {62'd0, state}, 64'd0);
        checkOutput("t7_halt", {63'd0, halt}, 64'd0);
        checkOutput("t7_instret", instret_cnt, 64'd0);
        checkOutput("t7_cycle", cycle_cnt, 64'd0);
        checkOutput("t7_tcount", {59'd0, trace_count}, 64'd0);
        checkOutput("t7_hpc", halt_pc, 64'd0);
        readGpr("t7_x5", 5'd5, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
